// File: rtl/kj_sync_tx_pkg.sv
// Shared definitions for the K/J line transmitter: line-state encodings ({k,j}),
// FSM states, default frame parameters and small line helpers.
package kj_sync_tx_pkg;

  typedef enum logic [1:0] {
    LINE_SE0 = 2'b00,
    LINE_J   = 2'b01,
    LINE_K   = 2'b10
  } line_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SYNC = 2'b01,
    ST_DATA = 2'b10,
    ST_EOP  = 2'b11
  } tx_state_t;

  localparam int SYNC_LEN_DEF  = 8;
  localparam int STUFF_LEN_DEF = 6;
  localparam int EOP_LEN_DEF   = 2;

  // SE0 has no NRZI partner; it falls back to idle J.
  function automatic line_t line_toggle(input line_t l);
    case (l)
      LINE_K:  return LINE_J;
      LINE_J:  return LINE_K;
      default: return LINE_J;
    endcase
  endfunction

  function automatic line_t sync_symbol(input int idx, input int len);
    if ((idx == len - 1) || ((idx % 2) == 0)) begin
      return LINE_K;
    end else begin
      return LINE_J;
    end
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/kj_sync_tx_nrzi_stuffer.sv
// NRZI line register with bit stuffing: a 0 (real or stuffed) toggles the line,
// a 1 holds it; after STUFF_LEN consecutive ones a stuffed 0 is requested.
module kj_nrzi_stuffer
  import kj_sync_tx_pkg::*;
#(
  parameter int STUFF_LEN = STUFF_LEN_DEF
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  bit_in,
  input  logic  bit_en,
  input  logic  stuff_clr,
  input  logic  force_en,
  input  line_t force_line,
  output line_t line,
  output logic  stuff_req
);

  localparam int ONES_W = $clog2(STUFF_LEN + 1);

  line_t             line_r;
  logic [ONES_W-1:0] ones_r;
  logic              toggle_s;

  assign stuff_req = (ones_r == ONES_W'(STUFF_LEN));
  assign toggle_s  = stuff_req || !bit_in;
  assign line      = line_r;

  // Line state and run-length of transmitted ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_r <= LINE_J;
      ones_r <= {ONES_W{1'b0}};
    end else begin
      if (force_en) begin
        line_r <= force_line;
      end else if (bit_en && toggle_s) begin
        line_r <= line_toggle(line_r);
      end else begin
        line_r <= line_r;
      end

      if (stuff_clr) begin
        ones_r <= {ONES_W{1'b0}};
      end else if (bit_en) begin
        ones_r <= toggle_s ? {ONES_W{1'b0}} : ones_r + ONES_W'(1);
      end else begin
        ones_r <= ones_r;
      end
    end
  end

endmodule

// File: rtl/kj_sync_tx.sv
// K/J line transmitter: SYNC pattern, NRZI bit-stuffed payload bytes (LSB first)
// and EOP, one symbol per clock, with a valid/ready byte handshake.
module kj_sync_tx
  import kj_sync_tx_pkg::*;
#(
  parameter int SYNC_LEN  = SYNC_LEN_DEF,
  parameter int STUFF_LEN = STUFF_LEN_DEF,
  parameter int EOP_LEN   = EOP_LEN_DEF
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       data_last,
  output logic       data_ready,
  output logic       k,
  output logic       j,
  output logic       tx_en,
  output logic       busy,
  output logic       done,
  output logic       tx_err
);

  localparam int CNT_W = $clog2(max3(SYNC_LEN, 8, EOP_LEN + 1));
  localparam logic [CNT_W-1:0] SYNC_LAST    = CNT_W'(SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] BIT_LAST     = CNT_W'(7);
  localparam logic [CNT_W-1:0] EOP_J_CNT    = CNT_W'(EOP_LEN);
  localparam logic [CNT_W-1:0] EOP_SE0_LAST = CNT_W'(EOP_LEN - 1);

  tx_state_t        state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [7:0]       shift_r;
  logic             last_r;
  logic             abort_r;
  logic             tx_en_r;
  logic             done_r;
  logic             tx_err_r;

  logic  ready_s;
  logic  load_s;
  logic  bit_s;
  logic  bit_en_s;
  logic  stuff_clr_s;
  logic  stuff_req_s;
  logic  force_en_s;
  line_t force_line_s;
  line_t line_s;

  // Byte handshake: last SYNC cycle, or final bit of a non-final byte unless a stuff is due.
  always_comb begin
    ready_s = 1'b0;
    if (state_r == ST_SYNC) begin
      ready_s = (cnt_r == SYNC_LAST);
    end else if (state_r == ST_DATA) begin
      ready_s = (cnt_r == BIT_LAST) && !last_r && !stuff_req_s;
    end else begin
      ready_s = 1'b0;
    end
  end

  // Next-symbol control for the line register.
  always_comb begin
    load_s       = ready_s && data_valid;
    bit_s        = load_s ? data_in[0] : shift_r[0];
    bit_en_s     = load_s || ((state_r == ST_DATA) && (stuff_req_s || (cnt_r != BIT_LAST)));
    stuff_clr_s  = (state_r != ST_DATA) && !load_s;
    force_en_s   = 1'b1;
    force_line_s = LINE_J;
    case (state_r)
      ST_IDLE: begin
        force_line_s = start ? LINE_K : LINE_J;
      end
      ST_SYNC: begin
        force_en_s   = !load_s;
        force_line_s = ready_s ? LINE_SE0 : sync_symbol(int'(cnt_r) + 1, SYNC_LEN);
      end
      ST_DATA: begin
        force_en_s   = !bit_en_s;
        force_line_s = LINE_SE0;
      end
      ST_EOP: begin
        force_line_s = (cnt_r < EOP_SE0_LAST) ? LINE_SE0 : LINE_J;
      end
      default: begin
        force_line_s = LINE_J;
      end
    endcase
  end

  kj_nrzi_stuffer #(
    .STUFF_LEN(STUFF_LEN)
  ) u_stuffer (
    .clk       (CLK),
    .rst       (RST),
    .bit_in    (bit_s),
    .bit_en    (bit_en_s),
    .stuff_clr (stuff_clr_s),
    .force_en  (force_en_s),
    .force_line(force_line_s),
    .line      (line_s),
    .stuff_req (stuff_req_s)
  );

  // Frame sequencing, byte shift register and status pulses.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r  <= ST_IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      shift_r  <= 8'h00;
      last_r   <= 1'b0;
      abort_r  <= 1'b0;
      tx_en_r  <= 1'b0;
      done_r   <= 1'b0;
      tx_err_r <= 1'b0;
    end else begin
      done_r   <= 1'b0;
      tx_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r <= ST_SYNC;
            cnt_r   <= {CNT_W{1'b0}};
            tx_en_r <= 1'b1;
            abort_r <= 1'b0;
          end
        end
        ST_SYNC: begin
          if (!ready_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else if (data_valid) begin
            state_r <= ST_DATA;
            cnt_r   <= {CNT_W{1'b0}};
            shift_r <= {1'b0, data_in[7:1]};
            last_r  <= data_last;
          end else begin
            state_r  <= ST_EOP;
            cnt_r    <= {CNT_W{1'b0}};
            tx_err_r <= 1'b1;
            abort_r  <= 1'b1;
          end
        end
        ST_DATA: begin
          // A stuff cycle consumes no payload bit.
          if (!stuff_req_s) begin
            if (cnt_r != BIT_LAST) begin
              cnt_r   <= cnt_r + CNT_W'(1);
              shift_r <= {1'b0, shift_r[7:1]};
            end else if (last_r) begin
              state_r <= ST_EOP;
              cnt_r   <= {CNT_W{1'b0}};
            end else if (data_valid) begin
              cnt_r   <= {CNT_W{1'b0}};
              shift_r <= {1'b0, data_in[7:1]};
              last_r  <= data_last;
            end else begin
              state_r  <= ST_EOP;
              cnt_r    <= {CNT_W{1'b0}};
              tx_err_r <= 1'b1;
              abort_r  <= 1'b1;
            end
          end
        end
        ST_EOP: begin
          if (cnt_r != EOP_J_CNT) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else begin
            state_r <= ST_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            tx_en_r <= 1'b0;
            done_r  <= !abort_r;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          tx_en_r <= 1'b0;
        end
      endcase
    end
  end

  assign data_ready = ready_s;
  assign k          = line_s[1];
  assign j          = line_s[0];
  assign tx_en      = tx_en_r;
  assign busy       = tx_en_r;
  assign done       = done_r;
  assign tx_err     = tx_err_r;

endmodule

// File: tb/tb_kj_sync_tx.sv
// Directed bench for kj_sync_tx: table of packets with hand-derived line symbol
// and data_ready traces, plus hand sequences for reset and start-while-busy.
module tb_kj_sync_tx;

  logic       CLK = 1'b0;
  logic       RST;
  logic       start;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_last;
  logic       data_ready;
  logic       k;
  logic       j;
  logic       tx_en;
  logic       busy;
  logic       done;
  logic       tx_err;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  kj_sync_tx dut (
    .CLK       (CLK),
    .RST       (RST),
    .start     (start),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_last (data_last),
    .data_ready(data_ready),
    .k         (k),
    .j         (j),
    .tx_en     (tx_en),
    .busy      (busy),
    .done      (done),
    .tx_err    (tx_err)
  );

  typedef struct {
    string      name;
    int         nbytes;
    int         nvalid;
    logic [7:0] b0;
    logic [7:0] b1;
    string      sym;
    string      rdy;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input string name, input int nbytes, input int nvalid,
                              input logic [7:0] b0, input logic [7:0] b1,
                              input string sym, input string rdy,
                              input int exp_done, input int exp_err);
    vec_t v;
    v.name = name; v.nbytes = nbytes; v.nvalid = nvalid; v.b0 = b0; v.b1 = b1;
    v.sym = sym; v.rdy = rdy; v.exp_done = exp_done; v.exp_err = exp_err;
    return v;
  endfunction

  function automatic string sym_char(input logic kk, input logic jj);
    case ({kk, jj})
      2'b10:   return "K";
      2'b01:   return "J";
      2'b00:   return "0";
      default: return "X";
    endcase
  endfunction

  task automatic chk_int(input string name, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic chk_str(input string name, input string got, input string exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got '%s', expected '%s'", name, got, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    string s, r, exp_sym, exp_rdy;
    int bi, len, done_cnt, done_idx, err_cnt, err_idx, bad;
    s = ""; r = ""; bi = 0; len = 0;
    done_cnt = 0; done_idx = -1; err_cnt = 0; err_idx = -1; bad = 0;
    exp_sym = {"KJKJKJKK", v.sym};
    exp_rdy = {".......1", v.rdy};
    @(negedge CLK);
    start = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      start = 1'b0;
      if (tx_en) begin
        s = {s, sym_char(k, j)};
        r = {r, data_ready ? "1" : "."};
        len++;
      end
      if (done) begin
        done_cnt++;
        if (done_idx < 0) done_idx = i;
      end
      if (tx_err) begin
        err_cnt++;
        if (err_idx < 0) err_idx = i;
      end
      if ((busy !== tx_en) || (data_ready && !tx_en)) bad++;
      if (data_ready) begin
        data_in    = (bi == 0) ? v.b0 : v.b1;
        data_valid = (bi < v.nvalid);
        data_last  = (bi == v.nbytes - 1);
        if (bi < v.nvalid) bi++;
      end else begin
        data_valid = 1'b0;
        data_last  = 1'b0;
      end
    end
    chk_str({v.name, ".symbols"}, s, exp_sym);
    chk_str({v.name, ".data_ready"}, r, exp_rdy);
    chk_int({v.name, ".tx_en_cycles"}, len, exp_sym.len());
    chk_int({v.name, ".done_count"}, done_cnt, v.exp_done);
    chk_int({v.name, ".tx_err_count"}, err_cnt, v.exp_err);
    chk_int({v.name, ".busy_consistency"}, bad, 0);
    if (v.exp_done != 0) chk_int({v.name, ".done_cycle"}, done_idx, exp_sym.len());
    if (v.exp_err != 0) chk_int({v.name, ".tx_err_cycle"}, err_idx, exp_sym.len() - 3);
  endtask

  initial begin
    string s;
    int    bad;
    RST = 1'b1; start = 1'b0; data_in = 8'h00; data_valid = 1'b0; data_last = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_int("reset_outputs", int'({k, j, tx_en, busy, done, tx_err, data_ready}), int'(7'b0100000));
    RST = 1'b0;
    @(negedge CLK);
    chk_int("idle_after_reset", int'({k, j, tx_en, busy, done, tx_err, data_ready}), int'(7'b0100000));

    vecs[0] = mk("zero_last", 1, 1, 8'h00, 8'h00, "JKJKJKJK00J", "...........", 1, 0);
    vecs[1] = mk("ff_last", 1, 1, 8'hFF, 8'h00, "KKKKKKJJJ00J", "............", 1, 0);
    vecs[2] = mk("3f_80", 2, 2, 8'h3F, 8'h80, "KKKKKKJKJKJKJKJKK00J", "........1...........", 1, 0);
    vecs[3] = mk("underrun_byte1", 2, 1, 8'h00, 8'h00, "JKJKJKJK00J", ".......1...", 0, 1);
    vecs[4] = mk("a5_last", 1, 1, 8'hA5, 8'h00, "KJJKJJKK00J", "...........", 1, 0);
    vecs[5] = mk("underrun_sync", 1, 0, 8'h00, 8'h00, "00J", "...", 0, 1);
    vecs[6] = mk("fc_00", 2, 2, 8'hFC, 8'h00, "JKKKKKKKJKJKJKJKJ00J", "........1...........", 1, 0);
    vecs[7] = mk("fc_last", 1, 1, 8'hFC, 8'h00, "JKKKKKKKJ00J", "............", 1, 0);

    for (int v = 0; v < 8; v++) begin
      run_vec(vecs[v]);
    end

    // Start pulses while busy must not disturb the frame; then reset mid-DATA.
    s = "";
    @(negedge CLK);
    start = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      start = (i == 3) || (i == 9);
      s = {s, sym_char(k, j)};
      data_valid = data_ready;
      data_last  = data_ready;
      data_in    = 8'h00;
    end
    start = 1'b0;
    chk_str("start_while_busy.symbols", s, "KJKJKJKKJKJK");
    #2 RST = 1'b1;
    #1;
    chk_int("async_reset_mid_data", int'({k, j, tx_en, busy, done, tx_err, data_ready}), int'(7'b0100000));
    @(posedge CLK);
    @(negedge CLK);
    chk_int("reset_held_next_edge", int'({k, j, tx_en, busy, done, tx_err, data_ready}), int'(7'b0100000));
    RST = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK);
      @(negedge CLK);
      if ({k, j, tx_en, busy, done, tx_err} !== 6'b010000) bad++;
    end
    chk_int("no_eop_after_reset", bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
